// File: rtl/darken_pkg.sv
// Shared pixel package.
// Holds the data width and darken shift amount that sibling image blocks
// agree on, so every stage of the pixel pipeline uses the same pixel width.
package darken_pkg;

  // Pixel data width in bits shared across the image pipeline.
  localparam int PIX_WIDTH = 8;

  // Default left-shift amount applied by the darken stage.
  localparam int DARKEN_SHIFT = 1;

  // Shift a pixel left and keep only the low w bits (no saturation).
  // Used as a reference formula by anything that needs the darken result
  // outside the block itself.
  function automatic logic [31:0] darken_value(input logic [31:0] pix,
                                               input int unsigned w,
                                               input int unsigned s);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (pix << s) & mask;
  endfunction

endpackage

// File: rtl/darken.sv
// darken: registered pixel left-shift.
// Each rising clock edge loads io_out with io_in shifted left by SHIFT and
// truncated to WIDTH bits. Bits shifted past the MSB are simply dropped.
// There is exactly one cycle of latency and one sample accepted per cycle.
//
// Ports:
//   clock  - single clock, rising edge active
//   reset  - asynchronous, active-high; clears io_out to 0 immediately
//   io_in  - unsigned input pixel, WIDTH bits
//   io_out - unsigned transformed pixel, WIDTH bits (registered)
module darken
  import darken_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int SHIFT = DARKEN_SHIFT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out
);

  // Reject parameter combinations that would make the shift meaningless.
  generate
    if ((WIDTH < 2) || (SHIFT < 0) || (SHIFT >= WIDTH)) begin : g_bad_params
      $error("darken: illegal parameters WIDTH=%0d SHIFT=%0d", WIDTH, SHIFT);
    end
  endgenerate

  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] out_reg;

  // The shift is evaluated at WIDTH bits, so the upper bits fall off here.
  always_comb begin
    result_next = io_in << SHIFT;
  end

  // The only state in the block; reset discards any in-flight sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
    end else begin
      out_reg <= result_next;
    end
  end

  assign io_out = out_reg;

endmodule

// File: tb/tb_darken.sv
// Directed testbench for darken: default 8-bit/shift-1 instance plus a
// SHIFT=0 instance and a WIDTH=4/SHIFT=2 instance sharing clock and reset.
module tb_darken;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic [7:0] in_s0 = 8'h00;
  logic [7:0] out_s0;
  logic [3:0] in_w4 = 4'h0;
  logic [3:0] out_w4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  darken u_dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  darken #(.WIDTH(8), .SHIFT(0)) u_shift0 (
    .clock  (clock),
    .reset  (reset),
    .io_in  (in_s0),
    .io_out (out_s0)
  );

  darken #(.WIDTH(4), .SHIFT(2)) u_w4 (
    .clock  (clock),
    .reset  (reset),
    .io_in  (in_w4),
    .io_out (out_w4)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] stream_in  [3] = '{8'h10, 8'h3C, 8'h7F};
  logic [7:0] stream_exp [3] = '{8'h20, 8'h78, 8'hFE};
  logic [7:0] wrap_in    [3] = '{8'h80, 8'hFF, 8'hC1};
  logic [7:0] wrap_exp   [3] = '{8'h00, 8'hFE, 8'h82};

  initial begin
    logic [7:0] prev_in;
    logic [7:0] exp_val;

    // Reset asserted between edges with a nonzero input present.
    io_in = 8'h55;
    #2;
    reset = 1'b1;
    #1;
    check("reset_immediate", io_out, 8'h00);
    check("reset_immediate_s0", out_s0, 8'h00);
    check("reset_immediate_w4", out_w4, 4'h0);
    tick();
    check("reset_held_1", io_out, 8'h00);
    tick();
    check("reset_held_2", io_out, 8'h00);
    reset = 1'b0;
    tick();
    check("reset_release", io_out, 8'hAA);

    // Nominal streaming, one result per edge.
    for (int i = 0; i < 3; i++) begin
      io_in = stream_in[i];
      tick();
      check($sformatf("stream_%0d", i), io_out, stream_exp[i]);
    end

    // Output holds between edges.
    #3;
    check("stream_hold", io_out, 8'hFE);

    // Wrap-around is plain truncation.
    for (int i = 0; i < 3; i++) begin
      io_in = wrap_in[i];
      tick();
      check($sformatf("wrap_%0d", i), io_out, wrap_exp[i]);
    end

    // Reset mid-stream discards the in-flight sample.
    io_in = 8'h40;
    tick();
    check("mid_before_reset", io_out, 8'h80);
    io_in = 8'h33;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_immediate", io_out, 8'h00);
    tick();
    check("mid_reset_held", io_out, 8'h00);
    io_in = 8'h01;
    reset = 1'b0;
    tick();
    check("mid_after_release", io_out, 8'h02);

    // Exhaustive sweep with a scoreboard of the previously sampled input.
    for (int i = 0; i < 256; i++) begin
      io_in = i[7:0];
      prev_in = io_in;
      tick();
      exp_val = {prev_in[6:0], 1'b0};
      check($sformatf("sweep_%02h", i), io_out, exp_val);
    end

    // Parameter variants.
    in_s0 = 8'hA5;
    in_w4 = 4'h7;
    tick();
    check("shift0_pass", out_s0, 8'hA5);
    check("w4_shift2", out_w4, 4'hC);
    in_s0 = 8'h3C;
    in_w4 = 4'h5;
    tick();
    check("shift0_pass_2", out_s0, 8'h3C);
    check("w4_shift2_2", out_w4, 4'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
